// File: rtl/bcd_display_scan.sv
// bcd_display_scan: converts a 16-bit binary count to five BCD digits with a
// sequential double-dabble engine. It then scans them onto an eight-digit,
// active-low seven-segment display, blanking leading zeros.
module bcd_display_scan #(
    parameter int DISPLAY_COUNTER = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    output logic        busy,
    output logic [6:0]  segments,
    output logic [7:0]  anodos
);

    localparam int RW = (DISPLAY_COUNTER > 2) ? $clog2(DISPLAY_COUNTER) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(DISPLAY_COUNTER - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  iter_q, iter_d;
    logic [19:0] disp_q, disp_d;
    logic [19:0] adj_w;

    logic [RW-1:0] refresh_q, refresh_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;

    logic [3:0] digit_w;
    logic [4:1] zero_above_w;

    // A BCD nibble of 5 or more would overflow past 9 when doubled, so pre-add 3.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Active-low {a..g} pattern for one decimal digit; non-decimal codes go dark.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign adj_w = {add3(acc_q[19:16]), add3(acc_q[15:12]), add3(acc_q[11:8]),
                    add3(acc_q[7:4]), add3(acc_q[3:0])};

    assign busy     = (state_q != S_IDLE);
    assign segments = seg_q;
    assign anodos   = an_q;

    // Converter next state: capture on load, 16 adjust-and-shift steps, then latch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        disp_d  = disp_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d = value;
                    acc_d   = 20'd0;
                    iter_d  = 4'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d   = (adj_w << 1) | {19'd0, shift_q[15]};
                shift_d = shift_q << 1;
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                disp_d  = acc_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Converter state and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= 16'd0;
            acc_q   <= 20'd0;
            iter_q  <= 4'd0;
            disp_q  <= 20'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
        end
    end

    // Scan timing: refresh counter wraps every DISPLAY_COUNTER cycles and steps the slot.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == REF_LAST) begin
            refresh_d = '0;
            idx_d     = idx_q + 3'd1;
        end
    end

    // Slot output: pick the digit, blank leading zeros and unused slots.
    always_comb begin
        zero_above_w[4] = (disp_q[19:16] == 4'd0);
        zero_above_w[3] = (disp_q[15:12] == 4'd0) && zero_above_w[4];
        zero_above_w[2] = (disp_q[11:8]  == 4'd0) && zero_above_w[3];
        zero_above_w[1] = (disp_q[7:4]   == 4'd0) && zero_above_w[2];
        digit_w = 4'd0;
        seg_d   = 7'h7F;
        an_d    = 8'hFF;
        case (idx_q)
            3'd0: digit_w = disp_q[3:0];
            3'd1: digit_w = disp_q[7:4];
            3'd2: digit_w = disp_q[11:8];
            3'd3: digit_w = disp_q[15:12];
            3'd4: digit_w = disp_q[19:16];
            default: digit_w = 4'd0;
        endcase
        if (idx_q == 3'd0 || (idx_q <= 3'd4 && !zero_above_w[idx_q[2:0] == 3'd0 ? 1 : idx_q])) begin
            seg_d = decode(digit_w);
            an_d  = ~(8'd1 << idx_q);
        end
    end

    // Scan counters and registered display outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_q <= '0;
            idx_q     <= 3'd0;
            seg_q     <= 7'b0000001;
            an_q      <= 8'b1111_1110;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a short scan period.
module tb_bcd_display_scan;

    localparam int DC = 4;

    logic        clock;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        busy;
    logic [6:0]  segments;
    logic [7:0]  anodos;

    int errors = 0;
    int checks = 0;
    int cyc;

    bcd_display_scan #(.DISPLAY_COUNTER(DC)) dut (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .segments (segments),
        .anodos   (anodos)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench-side cycle count since reset release, used to predict the scan slot.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int slot_of(input int c);
        return (c == 0) ? 0 : ((c - 1) / DC) % 8;
    endfunction

    function automatic logic [7:0] exp_an(input int s, input int n);
        logic [7:0] one;
        one = 8'd1;
        return (s < n) ? ~(one << s) : 8'hFF;
    endfunction

    function automatic logic [6:0] exp_seg(input int s, input int n, input logic [34:0] tbl);
        return (s < n) ? tbl[s*7 +: 7] : 7'h7F;
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Advance to the first cycle of predicted slot s (always at least one cycle).
    task automatic wait_slot(input int s);
        int n;
        n = 0;
        step();
        while (!(slot_of(cyc) == s && (cyc - 1) % DC == 0) && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL wait_slot%0d: slot start not reached, cyc=%0d", s, cyc);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_busy_low(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_timeout: busy=%b required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        value = 16'd0;
        load  = 1'b0;
        repeat (3) step();
        checks++;
        if (anodos !== 8'hFE || segments !== 7'b0000001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: anodos=%h segments=%b busy=%b required FE 0000001 0",
                     anodos, segments, busy);
        end
        reset = 1'b1;
        for (int s = 0; s < 8; s++) begin
            wait_slot(s);
            for (int r = 0; r < 2; r++) begin
                checks++;
                if (anodos !== exp_an(s, 1) || segments !== exp_seg(s, 1, {28'h0, 7'b0000001})) begin
                    errors++;
                    $display("FAIL reset_frame slot%0d: anodos=%h segments=%b required %h %b",
                             s, anodos, segments, exp_an(s, 1), exp_seg(s, 1, {28'h0, 7'b0000001}));
                end
                if (r == 0) repeat (DC - 1) step();
            end
        end
        wait_slot(0);
        checks++;
        if (anodos !== 8'hFE || segments !== 7'b0000001 || cyc != 8 * DC + 1) begin
            errors++;
            $display("FAIL reset_recur: anodos=%h segments=%b cyc=%0d required FE 0000001 %0d",
                     anodos, segments, cyc, 8 * DC + 1);
        end
    endtask

    task automatic test_conversion();
        logic [15:0] tv [3];
        logic [34:0] ts [3];
        int          tn [3];
        int          bc;
        tv[0] = 16'd1234;
        ts[0] = {7'h7F, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        tn[0] = 4;
        tv[1] = 16'd65535;
        ts[1] = {7'b0100000, 7'b0100100, 7'b0100100, 7'b0000110, 7'b0100100};
        tn[1] = 5;
        tv[2] = 16'd1000;
        ts[2] = {7'h7F, 7'b1001111, 7'b0000001, 7'b0000001, 7'b0000001};
        tn[2] = 4;
        for (int t = 0; t < 3; t++) begin
            do_load(tv[t]);
            bc = 0;
            while (busy === 1'b1 && bc < 40) begin
                bc++;
                step();
            end
            checks++;
            if (bc != 17) begin
                errors++;
                $display("FAIL conv%0d busy_len: cycles=%0d required 17", tv[t], bc);
            end
            for (int s = 0; s < 8; s++) begin
                wait_slot(s);
                for (int r = 0; r < 2; r++) begin
                    checks++;
                    if (anodos !== exp_an(s, tn[t]) || segments !== exp_seg(s, tn[t], ts[t])) begin
                        errors++;
                        $display("FAIL conv%0d slot%0d: anodos=%h segments=%b required %h %b",
                                 tv[t], s, anodos, segments, exp_an(s, tn[t]), exp_seg(s, tn[t], ts[t]));
                    end
                    if (r == 0) repeat (DC - 1) step();
                end
            end
        end
    endtask

    task automatic test_ignored_load();
        logic [34:0] tbl;
        tbl = {7'h7F, 7'h7F, 7'h7F, 7'b1001100, 7'b0010010};
        do_load(16'd42);
        step();
        do_load(16'd99);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ignored_busy: busy=%b required 1", busy);
        end
        repeat (40) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_not_queued: busy=%b required 0", busy);
        end
        for (int s = 0; s < 8; s++) begin
            wait_slot(s);
            checks++;
            if (anodos !== exp_an(s, 2) || segments !== exp_seg(s, 2, tbl)) begin
                errors++;
                $display("FAIL ignored_frame slot%0d: anodos=%h segments=%b required %h %b",
                         s, anodos, segments, exp_an(s, 2), exp_seg(s, 2, tbl));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] tbl;
        tbl = {7'h7F, 7'h7F, 7'h7F, 7'b0000100, 7'b0000100};
        do_load(16'd42);
        repeat (16) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy_n16: busy=%b required 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_n17: busy=%b required 0", busy);
        end
        do_load(16'd99);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_n18: busy=%b required 1", busy);
        end
        wait_busy_low("b2b");
        for (int s = 0; s < 8; s++) begin
            wait_slot(s);
            checks++;
            if (anodos !== exp_an(s, 2) || segments !== exp_seg(s, 2, tbl)) begin
                errors++;
                $display("FAIL b2b_frame slot%0d: anodos=%h segments=%b required %h %b",
                         s, anodos, segments, exp_an(s, 2), exp_seg(s, 2, tbl));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [34:0] tz;
        logic [34:0] t7;
        tz = {28'h0, 7'b0000001};
        t7 = {28'h0, 7'b0001111};
        do_load(16'd500);
        repeat (7) step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || anodos !== 8'hFE || segments !== 7'b0000001) begin
            errors++;
            $display("FAIL midreset_immediate: busy=%b anodos=%h segments=%b required 0 FE 0000001",
                     busy, anodos, segments);
        end
        step();
        step();
        reset = 1'b1;
        for (int s = 0; s < 8; s++) begin
            wait_slot(s);
            checks++;
            if (anodos !== exp_an(s, 1) || segments !== exp_seg(s, 1, tz)) begin
                errors++;
                $display("FAIL midreset_zero slot%0d: anodos=%h segments=%b required %h %b",
                         s, anodos, segments, exp_an(s, 1), exp_seg(s, 1, tz));
            end
        end
        do_load(16'd7);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reload: busy=%b required 1", busy);
        end
        wait_busy_low("midreset");
        for (int s = 0; s < 8; s++) begin
            wait_slot(s);
            checks++;
            if (anodos !== exp_an(s, 1) || segments !== exp_seg(s, 1, t7)) begin
                errors++;
                $display("FAIL midreset_seven slot%0d: anodos=%h segments=%b required %h %b",
                         s, anodos, segments, exp_an(s, 1), exp_seg(s, 1, t7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_ignored_load();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Downstream display stage for the push-button counter path. It accepts a 16-bit binary count on a load pulse and converts it to five BCD digits with a sequential double-dabble engine. It then time-multiplexes the digits onto the board's eight-digit, active-low seven-segment display with leading-zero blanking. It replaces direct binary-to-segment decoding, so counter values appear in decimal.

## Interface
- DISPLAY_COUNTER, 100000: clock cycles each digit slot stays active; must be ≥ 2.
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- value  in  16  binary value to display; sampled only when a load is accepted.
- load  in  1  single-cycle request to convert `value`.
- busy  out  1  high while a conversion is in progress.
- segments  out  7  {CA, CB, CC, CD, CE, CF, CG}, active-low.
- anodos  out  8  {AN7..AN0}, active-low, one-hot-low or all high.

## Operation
- The converter FSM has three states: IDLE, SHIFT and LATCH.
- IDLE
  - A load sampled high captures `value` into a 16-bit shift register.
  - It clears the 20-bit BCD accumulator and the iteration counter.
  - Next state: SHIFT.
- SHIFT
  - Each cycle, every accumulator nibble ≥ 5 gets +3.
  - Then {accumulator, shift register} shifts left by one.
  - After the 16th shift, next state: LATCH.
- LATCH
  - Copies the accumulator into the 20-bit display register (digit0 = ones … digit4 = ten-thousands).
  - Next state: IDLE.
- busy = 1 in SHIFT and LATCH. load is ignored while busy; it is not queued.
- Full range 0..65535; 65535 displays as digits 6,5,5,3,5 (digit4..digit0).
- Scan
  - Refresh counter runs 0..DISPLAY_COUNTER-1 and wraps.
  - On wrap, digit index 0..7 increments, wrapping 7→0.
- Per-slot output for index i:
  - i = 0: anodos[0] = 0, segments = decode(digit0). The ones digit is always shown, including 0.
  - i = 1..4: if digit i and all higher digits 1..4 are zero, the slot is blank. Otherwise anodos[i] = 0 and segments = decode(digit i). Interior zeros are shown.
  - i = 5..7: always blank.
  - Blank means anodos = 8'hFF and segments = 7'h7F.
- Decode, active-low {a..g}:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- Reset (async, reset = 0):
  - FSM goes to IDLE, busy = 0, and the shift register, accumulator and display register clear to 0.
  - Refresh counter = 0, index = 0.
  - anodos = 8'b1111_1110, segments = 7'b0000001.
- Reset mid-conversion aborts the conversion and the display returns to 0. The first load after reset release is accepted normally.
- A display register update mid-slot takes effect on the next output register update without disturbing scan timing.

## Timing
- load high at edge N, with FSM in IDLE:
  - Capture occurs at N; busy goes high after N.
  - Shifts occur at edges N+1..N+16.
  - The display register updates at edge N+17, and busy falls after N+17.
  - The earliest accepted next load is sampled at edge N+18.
- Scan timing:
  - The index advances at the edge where the refresh counter equals DISPLAY_COUNTER-1.
  - A full frame is 8·DISPLAY_COUNTER cycles.
- segments and anodos are registered:
  - They reflect index and display register state from the previous cycle.
  - One-cycle lag after an index change or display register update.
  - No combinational path from inputs to outputs.

## Test plan
- Reset with DISPLAY_COUNTER = 4:
  - anodos = FE, segments = 0000001 during reset and the first slot.
  - Slots 1..7 are all FF / 7F.
  - Slot 0 recurs every 32 cycles.
- load with value = 1234:
  - busy is high for exactly 17 cycles.
  - Slots 0..3 show 1001100, 0000110, 0010010, 1001111.
  - Slot 4 is blank.
- load with value = 65535:
  - Slots 0..4 show 5,3,5,5,6 (0100100, 0000110, 0100100, 0100100, 0100000).
- Interior zeros, value = 1000:
  - Slots 0..2 show 0000001, slot 3 shows 1001111, slot 4 is blank.
- load 42, then load 99 two cycles later:
  - The second load is ignored; the display shows 4,2.
  - A load of 99 at N+18 is accepted.
- Reset pulled low 8 cycles into a conversion of 500:
  - busy = 0 immediately and the display shows 0.
  - After release, load 7 shows 0001111 in slot 0 with slots 1..7 blank.
